// File: rtl/alu_ctrl_decoder_if.sv
// Decode-stage request/response bundle for alu_ctrl_decoder.
// The master drives instruction fields and pipeline controls; the slave returns ALU controls.
interface alu_ctrl_decoder_if #(
    parameter int unsigned CTR_BUS_WIDTH = 4,
    parameter int unsigned OP_WIDTH      = 6
);
    logic                     i_valid;
    logic                     i_stall;
    logic                     i_flush;
    logic [OP_WIDTH-1:0]      i_opcode;
    logic [OP_WIDTH-1:0]      i_funct;
    logic [CTR_BUS_WIDTH-1:0] o_ctr_code;
    logic [1:0]               o_sel_a;
    logic [1:0]               o_sel_b;
    logic [1:0]               o_ext;
    logic                     o_valid;
    logic                     o_illegal;

    modport master (
        output i_valid, i_stall, i_flush, i_opcode, i_funct,
        input  o_ctr_code, o_sel_a, o_sel_b, o_ext, o_valid, o_illegal
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_opcode, i_funct,
        output o_ctr_code, o_sel_a, o_sel_b, o_ext, o_valid, o_illegal
    );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// Registered ALU-control decode at the ID/EX boundary: MIPS opcode/funct to ALU op,
// operand selects and immediate extension, with stall/flush and illegal-encoding flag.
module alu_ctrl_decoder #(
    parameter int unsigned CTR_BUS_WIDTH = 4,
    parameter int unsigned OP_WIDTH      = 6
) (
    input logic               i_clk,
    input logic               i_reset,
    alu_ctrl_decoder_if.slave bus
);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SLL  = CTR_BUS_WIDTH'(0);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SRL  = CTR_BUS_WIDTH'(1);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SRA  = CTR_BUS_WIDTH'(2);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_ADD  = CTR_BUS_WIDTH'(3);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_ADDU = CTR_BUS_WIDTH'(4);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SUB  = CTR_BUS_WIDTH'(5);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SUBU = CTR_BUS_WIDTH'(6);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_AND  = CTR_BUS_WIDTH'(7);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_OR   = CTR_BUS_WIDTH'(8);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_XOR  = CTR_BUS_WIDTH'(9);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_NOR  = CTR_BUS_WIDTH'(10);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SLT  = CTR_BUS_WIDTH'(11);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SLLV = CTR_BUS_WIDTH'(12);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SRLV = CTR_BUS_WIDTH'(13);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SRAV = CTR_BUS_WIDTH'(14);
    localparam logic [CTR_BUS_WIDTH-1:0] ALU_SC_B = CTR_BUS_WIDTH'(15);

    localparam logic [1:0] SEL_RS    = 2'd0;
    localparam logic [1:0] SEL_SHAMT = 2'd1;
    localparam logic [1:0] SEL_RT    = 2'd2;
    localparam logic [1:0] SELB_RT   = 2'd0;
    localparam logic [1:0] SELB_IMM  = 2'd1;
    localparam logic [1:0] SELB_RS   = 2'd2;
    localparam logic [1:0] EXT_SIGN  = 2'd0;
    localparam logic [1:0] EXT_ZERO  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    logic [CTR_BUS_WIDTH-1:0] w_ctr;
    logic [1:0]               w_sel_a;
    logic [1:0]               w_sel_b;
    logic [1:0]               w_ext;
    logic                     w_illegal;

    logic [CTR_BUS_WIDTH-1:0] r_ctr;
    logic [1:0]               r_sel_a;
    logic [1:0]               r_sel_b;
    logic [1:0]               r_ext;
    logic                     r_valid;
    logic                     r_illegal;

    // Defaults are the illegal/bubble pattern; each legal encoding overrides what it needs.
    always_comb begin
        w_ctr     = ALU_ADDU;
        w_sel_a   = SEL_RS;
        w_sel_b   = SELB_RT;
        w_ext     = EXT_SIGN;
        w_illegal = 1'b0;
        case (bus.i_opcode)
            OP_WIDTH'(6'h00): begin
                case (bus.i_funct)
                    OP_WIDTH'(6'h00): begin w_ctr = ALU_SLL;  w_sel_a = SEL_SHAMT; end
                    OP_WIDTH'(6'h02): begin w_ctr = ALU_SRL;  w_sel_a = SEL_SHAMT; end
                    OP_WIDTH'(6'h03): begin w_ctr = ALU_SRA;  w_sel_a = SEL_SHAMT; end
                    OP_WIDTH'(6'h04): begin w_ctr = ALU_SLLV; w_sel_a = SEL_RT; w_sel_b = SELB_RS; end
                    OP_WIDTH'(6'h06): begin w_ctr = ALU_SRLV; w_sel_a = SEL_RT; w_sel_b = SELB_RS; end
                    OP_WIDTH'(6'h07): begin w_ctr = ALU_SRAV; w_sel_a = SEL_RT; w_sel_b = SELB_RS; end
                    OP_WIDTH'(6'h08),
                    OP_WIDTH'(6'h09): w_ctr = ALU_ADDU;
                    OP_WIDTH'(6'h20): w_ctr = ALU_ADD;
                    OP_WIDTH'(6'h21): w_ctr = ALU_ADDU;
                    OP_WIDTH'(6'h22): w_ctr = ALU_SUB;
                    OP_WIDTH'(6'h23): w_ctr = ALU_SUBU;
                    OP_WIDTH'(6'h24): w_ctr = ALU_AND;
                    OP_WIDTH'(6'h25): w_ctr = ALU_OR;
                    OP_WIDTH'(6'h26): w_ctr = ALU_XOR;
                    OP_WIDTH'(6'h27): w_ctr = ALU_NOR;
                    OP_WIDTH'(6'h2A): w_ctr = ALU_SLT;
                    default:          w_illegal = 1'b1;
                endcase
            end
            OP_WIDTH'(6'h02),
            OP_WIDTH'(6'h03): w_ctr = ALU_SC_B;
            OP_WIDTH'(6'h04),
            OP_WIDTH'(6'h05): w_ctr = ALU_SUBU;
            OP_WIDTH'(6'h08): begin w_ctr = ALU_ADD;  w_sel_b = SELB_IMM; w_ext = EXT_SIGN;  end
            OP_WIDTH'(6'h09): begin w_ctr = ALU_ADDU; w_sel_b = SELB_IMM; w_ext = EXT_SIGN;  end
            OP_WIDTH'(6'h0A): begin w_ctr = ALU_SLT;  w_sel_b = SELB_IMM; w_ext = EXT_SIGN;  end
            OP_WIDTH'(6'h0C): begin w_ctr = ALU_AND;  w_sel_b = SELB_IMM; w_ext = EXT_ZERO;  end
            OP_WIDTH'(6'h0D): begin w_ctr = ALU_OR;   w_sel_b = SELB_IMM; w_ext = EXT_ZERO;  end
            OP_WIDTH'(6'h0E): begin w_ctr = ALU_XOR;  w_sel_b = SELB_IMM; w_ext = EXT_ZERO;  end
            OP_WIDTH'(6'h0F): begin w_ctr = ALU_SC_B; w_sel_b = SELB_IMM; w_ext = EXT_UPPER; end
            OP_WIDTH'(6'h20), OP_WIDTH'(6'h21), OP_WIDTH'(6'h23),
            OP_WIDTH'(6'h24), OP_WIDTH'(6'h25), OP_WIDTH'(6'h27),
            OP_WIDTH'(6'h28), OP_WIDTH'(6'h29), OP_WIDTH'(6'h2B): begin
                w_ctr   = ALU_ADDU;
                w_sel_b = SELB_IMM;
                w_ext   = EXT_SIGN;
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal encodings emit the bubble controls regardless of partial decode.
        if (w_illegal) begin
            w_ctr   = ALU_ADDU;
            w_sel_a = SEL_RS;
            w_sel_b = SELB_RT;
            w_ext   = EXT_SIGN;
        end
    end

    // Flush beats stall beats load; invalid loads take the bubble so X fields never reach state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ctr     <= ALU_ADDU;
            r_sel_a   <= SEL_RS;
            r_sel_b   <= SELB_RT;
            r_ext     <= EXT_SIGN;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.i_flush || (!bus.i_stall && !bus.i_valid)) begin
            r_ctr     <= ALU_ADDU;
            r_sel_a   <= SEL_RS;
            r_sel_b   <= SELB_RT;
            r_ext     <= EXT_SIGN;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!bus.i_stall) begin
            r_ctr     <= w_ctr;
            r_sel_a   <= w_sel_a;
            r_sel_b   <= w_sel_b;
            r_ext     <= w_ext;
            r_valid   <= !w_illegal;
            r_illegal <= w_illegal;
        end
    end

    assign bus.o_ctr_code = r_ctr;
    assign bus.o_sel_a    = r_sel_a;
    assign bus.o_sel_b    = r_sel_b;
    assign bus.o_ext      = r_ext;
    assign bus.o_valid    = r_valid;
    assign bus.o_illegal  = r_illegal;
endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed bench for alu_ctrl_decoder: hand-computed expected control words checked one cycle
// after each drive, including async reset, stall/flush priority and X-masking on invalid cycles.
module tb_alu_ctrl_decoder;
    logic i_clk;
    logic i_reset;
    int   checks;
    int   failures;

    alu_ctrl_decoder_if #(.CTR_BUS_WIDTH(4), .OP_WIDTH(6)) bus ();

    alu_ctrl_decoder #(.CTR_BUS_WIDTH(4), .OP_WIDTH(6)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected word layout: {ctr[3:0], sel_a[1:0], sel_b[1:0], ext[1:0], valid, illegal}
    function automatic logic [11:0] mk(input int ctr, input int a, input int b, input int e,
                                       input bit v, input bit il);
        logic [11:0] w;
        w = {4'(ctr), 2'(a), 2'(b), 2'(e), v, il};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] got;
        got = {bus.o_ctr_code, bus.o_sel_a, bus.o_sel_b, bus.o_ext, bus.o_valid, bus.o_illegal};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit f,
                         input logic [5:0] op, input logic [5:0] fn);
        bus.i_valid  = v;
        bus.i_stall  = s;
        bus.i_flush  = f;
        bus.i_opcode = op;
        bus.i_funct  = fn;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [11:0] bubble;
        checks   = 0;
        failures = 0;
        bubble   = mk(4, 0, 0, 0, 1'b0, 1'b0);

        i_reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 6'h0D, 6'h00);
        #12;
        chk("reset_bubble", bubble);

        i_reset = 1'b1;
        tick();
        chk("ori", mk(8, 0, 1, 1, 1'b1, 1'b0));

        // Asynchronous reset mid-stream, no clock edge in between
        i_reset = 1'b0;
        #2;
        chk("async_reset", bubble);
        #2;
        i_reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h20);
        tick();
        chk("add", mk(3, 0, 0, 0, 1'b1, 1'b0));

        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h00); tick(); chk("sll",  mk(0, 1, 0, 0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h07); tick(); chk("srav", mk(14, 2, 2, 0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h0F, 6'h00); tick(); chk("lui",  mk(15, 0, 1, 2, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h0A, 6'h00); tick(); chk("slti", mk(11, 0, 1, 0, 1'b1, 1'b0));

        drive(1'b1, 1'b0, 1'b0, 6'h0C, 6'h00); tick(); chk("andi", mk(7, 0, 1, 1, 1'b1, 1'b0));
        drive(1'b1, 1'b1, 1'b0, 6'h00, 6'h22);
        tick(); chk("stall1", mk(7, 0, 1, 1, 1'b1, 1'b0));
        tick(); chk("stall2", mk(7, 0, 1, 1, 1'b1, 1'b0));
        tick(); chk("stall3", mk(7, 0, 1, 1, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h22); tick(); chk("sub", mk(5, 0, 0, 0, 1'b1, 1'b0));

        drive(1'b1, 1'b1, 1'b1, 6'h23, 6'h00); tick(); chk("flush_over_stall", bubble);
        drive(1'b1, 1'b0, 1'b0, 6'h23, 6'h00); tick(); chk("lw", mk(4, 0, 1, 0, 1'b1, 1'b0));

        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h3F); tick(); chk("illegal_funct", mk(4, 0, 0, 0, 1'b0, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 6'h04, 6'h00); tick(); chk("beq", mk(6, 0, 0, 0, 1'b1, 1'b0));

        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h08); tick(); chk("jr", mk(4, 0, 0, 0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h02, 6'h15); tick(); chk("j", mk(15, 0, 0, 0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h03); tick(); chk("sra", mk(2, 1, 0, 0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h0E, 6'h00); tick(); chk("xori", mk(9, 0, 1, 1, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h2B, 6'h00); tick(); chk("sw", mk(4, 0, 1, 0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h27); tick(); chk("nor", mk(10, 0, 0, 0, 1'b1, 1'b0));

        // Illegal opcode then flush alone clears o_illegal
        drive(1'b1, 1'b0, 1'b0, 6'h01, 6'h00); tick(); chk("illegal_op", mk(4, 0, 0, 0, 1'b0, 1'b1));
        drive(1'b1, 1'b0, 1'b1, 6'h0D, 6'h00); tick(); chk("flush_only", bubble);

        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h3E); tick(); chk("illegal_again", mk(4, 0, 0, 0, 1'b0, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 6'bxxxxxx, 6'bxxxxxx);
        tick(); chk("x_invalid1", bubble);
        tick(); chk("x_invalid2", bubble);

        drive(1'b1, 1'b0, 1'b0, 6'h00, 6'h2A); tick(); chk("slt", mk(11, 0, 0, 0, 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
